// File: rtl/guitar_param_pkg.sv
// guitar_param_pkg: address map, divider width and parameter index mapping for the guitar parameter bank.
package guitar_param_pkg;
    localparam logic [12:0] CTRL        = 13'h000;
    localparam logic [12:0] COMMIT      = 13'h001;
    localparam logic [12:0] STEP        = 13'h002;
    localparam logic [12:0] DIV         = 13'h003;
    localparam logic [12:0] SHADOW_BASE = 13'h010;
    localparam logic [12:0] ACTIVE_BASE = 13'h080;
    localparam int DIV_W = 16;

    function automatic int flat_idx(input int ch, input int p, input int n_par);
        return ch * n_par + p;
    endfunction
endpackage

// File: rtl/guitar_param_slew.sv
// guitar_param_slew: holds one committed target and slews the active value toward it by at most step per tick.
module guitar_param_slew #(
    parameter int DW = 16
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic [DW-1:0] target_i,
    input  logic [DW-1:0] step_i,
    input  logic          tick_i,
    input  logic          load_i,
    output logic [DW-1:0] active_o,
    output logic          at_target_o
);
    logic [DW-1:0] r_target, r_active, w_mv;
    logic [DW:0]   w_diff;
    logic          w_up;

    assign w_up   = r_target > r_active;
    assign w_diff = w_up ? {1'b0, r_target} - {1'b0, r_active} : {1'b0, r_active} - {1'b0, r_target};
    // Clip the move to the remaining distance so the ramp lands exactly on target.
    assign w_mv   = ({1'b0, step_i} < w_diff) ? step_i : w_diff[DW-1:0];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_target <= '0;
            r_active <= '0;
        end else begin
            if (load_i) r_target <= target_i;
            if (step_i == '0) r_active <= r_target;
            else if (tick_i) r_active <= w_up ? r_active + w_mv : r_active - w_mv;
        end
    end

    assign active_o    = r_active;
    assign at_target_o = r_active == r_target;
endmodule

// File: rtl/guitar_param_bank.sv
// guitar_param_bank: bus-mapped shadow/target/active effect parameter bank with commit and
// rate-limited slewing of every active value toward its committed target.
module guitar_param_bank
    import guitar_param_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int N_PAR   = 4,
    parameter int DW      = 16,
    parameter int DIV_RST = 1000
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic [31:0]              addr_i,
    input  logic [31:0]              wdata_i,
    input  logic                     wen_i,
    input  logic                     ren_i,
    output logic [31:0]              rdata_o,
    output logic                     ack_o,
    output logic                     err_o,
    output logic                     bypass_o,
    output logic [N_CH*N_PAR*DW-1:0] param_o,
    output logic                     busy_o,
    output logic                     done_o
);
    localparam int          NK   = N_CH * N_PAR;
    localparam int          KW   = (NK > 1) ? $clog2(NK) : 1;
    localparam logic [12:0] NK_W = 13'(NK);

    logic [12:0]      w_idx, w_sh_off, w_ac_off;
    logic             w_sh_hit, w_ac_hit, w_map, w_tick, w_commit, w_busy_nxt, w_unused;
    logic [31:0]      w_rd;
    logic [NK-1:0]    w_at;
    logic [DW-1:0]    w_active [NK];
    logic [DW-1:0]    r_shadow [NK];
    logic [DW-1:0]    r_step;
    logic [DIV_W-1:0] r_div, r_cnt;
    logic             r_bypass, r_busy, r_done, r_ack, r_err;
    logic [31:0]      r_rdata;

    assign w_idx      = addr_i[15:3];
    assign w_sh_off   = w_idx - SHADOW_BASE;
    assign w_ac_off   = w_idx - ACTIVE_BASE;
    assign w_sh_hit   = w_sh_off < NK_W;
    assign w_ac_hit   = w_ac_off < NK_W;
    // >= keeps the counter from running past a freshly lowered divider.
    assign w_tick     = r_cnt >= r_div;
    assign w_commit   = wen_i && w_idx == COMMIT && wdata_i[0];
    assign w_busy_nxt = ~&w_at;
    assign w_unused   = ^{addr_i[31:16], addr_i[2:0], wdata_i[31:16]};

    always_comb begin
        w_map = 1'b1;
        w_rd  = '0;
        if (w_idx == CTRL) w_rd = {31'b0, r_bypass};
        else if (w_idx == COMMIT) w_rd = {31'b0, r_busy};
        else if (w_idx == STEP) w_rd = 32'(r_step);
        else if (w_idx == DIV) w_rd = 32'(r_div);
        else if (w_sh_hit) w_rd = 32'(r_shadow[w_sh_off[KW-1:0]]);
        else if (w_ac_hit) w_rd = 32'(w_active[w_ac_off[KW-1:0]]);
        else w_map = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_bypass <= 1'b0;
            r_step   <= DW'(1);
            r_div    <= DIV_W'(DIV_RST);
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
            for (int k = 0; k < NK; k++) r_shadow[k] <= '0;
        end else begin
            r_cnt   <= w_tick ? '0 : r_cnt + DIV_W'(1);
            r_busy  <= w_busy_nxt;
            r_done  <= r_busy & ~w_busy_nxt;
            r_ack   <= wen_i | ren_i;
            r_err   <= (wen_i | ren_i) & ~w_map;
            r_rdata <= (ren_i && w_map) ? w_rd : '0;
            if (wen_i && w_idx == CTRL) r_bypass <= wdata_i[0];
            if (wen_i && w_idx == STEP) r_step <= wdata_i[DW-1:0];
            if (wen_i && w_idx == DIV) r_div <= wdata_i[DIV_W-1:0];
            if (wen_i && w_sh_hit) r_shadow[w_sh_off[KW-1:0]] <= wdata_i[DW-1:0];
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        for (genvar p = 0; p < N_PAR; p++) begin : g_par
            localparam int K = flat_idx(c, p, N_PAR);
            guitar_param_slew #(.DW(DW)) u_slew (
                .clk_i       (clk_i),
                .rstn_i      (rstn_i),
                .target_i    (r_shadow[K]),
                .step_i      (r_step),
                .tick_i      (w_tick),
                .load_i      (w_commit),
                .active_o    (w_active[K]),
                .at_target_o (w_at[K])
            );
            assign param_o[K*DW +: DW] = w_active[K];
        end
    end

    assign rdata_o  = r_rdata;
    assign ack_o    = r_ack;
    assign err_o    = r_err;
    assign bypass_o = r_bypass;
    assign busy_o   = r_busy;
    assign done_o   = r_done;
endmodule

// File: tb/tb_guitar_param_bank.sv
// tb_guitar_param_bank: directed and randomized checks of guitar_param_bank against a behavioural model.
module tb_guitar_param_bank;
    logic         clk_i = 1'b0;
    logic         rstn_i, wen_i, ren_i;
    logic [31:0]  addr_i, wdata_i, rdata_o;
    logic         ack_o, err_o, bypass_o, busy_o, done_o;
    logic [255:0] param_o;
    int checks = 0;
    int failures = 0;

    int unsigned m_shadow [16];
    int unsigned m_target [16];
    int unsigned m_active [16];
    int unsigned m_step, m_div, m_cnt, m_rdata, t_rd;
    int          t_idx;
    bit          m_bypass, m_busy, m_done, m_ack, m_err, t_busy_old, t_tick, t_map;

    always #5 clk_i = ~clk_i;

    guitar_param_bank dut (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .wen_i    (wen_i),
        .ren_i    (ren_i),
        .rdata_o  (rdata_o),
        .ack_o    (ack_o),
        .err_o    (err_o),
        .bypass_o (bypass_o),
        .param_o  (param_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    function automatic int unsigned umin(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

    function automatic int unsigned model_read(input int idx, input bit busy_old, output bit map);
        map = 1'b1;
        if (idx == 0) return {31'b0, m_bypass};
        if (idx == 1) return {31'b0, busy_old};
        if (idx == 2) return m_step;
        if (idx == 3) return m_div;
        if (idx >= 16 && idx < 32) return m_shadow[idx-16];
        if (idx >= 128 && idx < 144) return m_active[idx-128];
        map = 1'b0;
        return 0;
    endfunction

    // Behavioural model: one update per clock, built from the register-map and slew rules.
    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int k = 0; k < 16; k++) begin
                m_shadow[k] = 0;
                m_target[k] = 0;
                m_active[k] = 0;
            end
            m_step = 1; m_div = 1000; m_cnt = 0; m_bypass = 0;
            m_busy = 0; m_done = 0; m_ack = 0; m_err = 0; m_rdata = 0;
        end else begin
            t_idx = int'(addr_i[15:3]);
            t_busy_old = m_busy;
            m_busy = 0;
            for (int k = 0; k < 16; k++) if (m_active[k] != m_target[k]) m_busy = 1;
            m_done = t_busy_old && !m_busy;
            t_tick = m_cnt >= m_div;
            m_cnt = t_tick ? 0 : m_cnt + 1;
            t_rd = model_read(t_idx, t_busy_old, t_map);
            m_ack = wen_i || ren_i;
            m_err = m_ack && !t_map;
            m_rdata = (ren_i && t_map) ? t_rd : 0;
            for (int k = 0; k < 16; k++) begin
                if (m_step == 0) m_active[k] = m_target[k];
                else if (t_tick) begin
                    if (m_target[k] > m_active[k]) m_active[k] += umin(m_step, m_target[k] - m_active[k]);
                    else m_active[k] -= umin(m_step, m_active[k] - m_target[k]);
                end
            end
            if (wen_i) begin
                if (t_idx == 0) m_bypass = wdata_i[0];
                if (t_idx == 1 && wdata_i[0]) for (int k = 0; k < 16; k++) m_target[k] = m_shadow[k];
                if (t_idx == 2) m_step = wdata_i[15:0];
                if (t_idx == 3) m_div = wdata_i[15:0];
                if (t_idx >= 16 && t_idx < 32) m_shadow[t_idx-16] = wdata_i[15:0];
            end
        end
    end

    // Called just after a falling edge; returns on the next falling edge with the response visible.
    task automatic bus(input bit we, input bit re, input logic [12:0] idx, input logic [31:0] d);
        logic [31:0] r;
        r = $urandom();
        wen_i = we;
        ren_i = re;
        addr_i = {r[31:16], idx, r[2:0]};
        wdata_i = d;
        @(negedge clk_i);
        wen_i = 1'b0;
        ren_i = 1'b0;
    endtask

    task automatic test_reset;
        rstn_i = 1'b0; wen_i = 1'b0; ren_i = 1'b0; addr_i = '0; wdata_i = '0;
        #23 rstn_i = 1'b1;
        @(negedge clk_i);
        checks++; if (param_o !== '0) begin failures++; $display("FAIL reset_param got=%h exp=0", param_o); end
        checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b%b exp=00", busy_o, done_o); end
        checks++; if (ack_o !== 1'b0 || err_o !== 1'b0 || rdata_o !== '0) begin failures++; $display("FAIL reset_bus ack=%b err=%b rdata=%h exp=0", ack_o, err_o, rdata_o); end
        bus(0, 1, 13'h002, 0);
        checks++; if (ack_o !== 1'b1 || err_o !== 1'b0 || rdata_o !== 32'd1) begin failures++; $display("FAIL reset_step ack=%b err=%b rdata=%h exp=1", ack_o, err_o, rdata_o); end
        bus(0, 1, 13'h003, 0);
        checks++; if (rdata_o !== 32'd1000) begin failures++; $display("FAIL reset_div got=%0d exp=1000", rdata_o); end
    endtask

    task automatic test_shadow;
        bus(1, 0, 13'h015, 32'hABCD_0100);
        @(negedge clk_i);
        checks++; if (param_o[5*16 +: 16] !== 16'h0) begin failures++; $display("FAIL shadow_nocommit got=%h exp=0", param_o[5*16 +: 16]); end
        bus(0, 1, 13'h015, 0);
        checks++; if (rdata_o !== 32'h100) begin failures++; $display("FAIL shadow_read got=%h exp=100", rdata_o); end
    endtask

    task automatic test_ramp;
        logic [15:0] exp [4] = '{16'h40, 16'h80, 16'hC0, 16'h100};
        bus(1, 0, 13'h003, 0);
        bus(1, 0, 13'h002, 32'h40);
        bus(1, 0, 13'h001, 1);
        checks++; if (param_o[5*16 +: 16] !== 16'h0) begin failures++; $display("FAIL ramp_load got=%h exp=0", param_o[5*16 +: 16]); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            checks++; if (param_o[5*16 +: 16] !== exp[i]) begin failures++; $display("FAIL ramp_step%0d got=%h exp=%h", i, param_o[5*16 +: 16], exp[i]); end
        end
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL ramp_busy got=%b exp=1", busy_o); end
        @(negedge clk_i);
        checks++; if (busy_o !== 1'b0 || done_o !== 1'b1) begin failures++; $display("FAIL ramp_done busy=%b done=%b exp=0/1", busy_o, done_o); end
        @(negedge clk_i);
        checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL ramp_done_pulse got=%b exp=0", done_o); end
    endtask

    task automatic test_midramp;
        logic [15:0] exp [3] = '{16'h40, 16'h0, 16'h0};
        bus(1, 0, 13'h002, 0);
        bus(1, 0, 13'h015, 0);
        bus(1, 0, 13'h001, 1);
        repeat (3) @(negedge clk_i);
        checks++; if (param_o[5*16 +: 16] !== 16'h0) begin failures++; $display("FAIL jump got=%h exp=0", param_o[5*16 +: 16]); end
        bus(1, 0, 13'h002, 32'h40);
        bus(1, 0, 13'h015, 32'h100);
        bus(1, 0, 13'h001, 1);
        bus(1, 0, 13'h015, 0);
        checks++; if (param_o[5*16 +: 16] !== 16'h40) begin failures++; $display("FAIL mid_shadow got=%h exp=40", param_o[5*16 +: 16]); end
        bus(1, 0, 13'h001, 1);
        checks++; if (param_o[5*16 +: 16] !== 16'h80) begin failures++; $display("FAIL mid_commit got=%h exp=80", param_o[5*16 +: 16]); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            checks++; if (param_o[5*16 +: 16] !== exp[i]) begin failures++; $display("FAIL mid_down%0d got=%h exp=%h", i, param_o[5*16 +: 16], exp[i]); end
        end
        repeat (3) @(negedge clk_i);
    endtask

    task automatic test_clip;
        logic [15:0] exp [6] = '{16'h30, 16'h60, 16'h90, 16'hC0, 16'hF0, 16'h100};
        bus(1, 0, 13'h002, 32'h30);
        bus(1, 0, 13'h015, 32'h100);
        bus(1, 0, 13'h001, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            checks++; if (param_o[5*16 +: 16] !== exp[i]) begin failures++; $display("FAIL clip%0d got=%h exp=%h", i, param_o[5*16 +: 16], exp[i]); end
        end
        repeat (3) @(negedge clk_i);
    endtask

    task automatic test_err;
        logic [255:0] snap;
        bus(0, 1, 13'h07F, 0);
        checks++; if (ack_o !== 1'b1 || err_o !== 1'b1 || rdata_o !== '0) begin failures++; $display("FAIL unmapped ack=%b err=%b rdata=%h exp=1/1/0", ack_o, err_o, rdata_o); end
        snap = param_o;
        bus(1, 0, 13'h085, 32'h1234);
        checks++; if (ack_o !== 1'b1 || err_o !== 1'b0) begin failures++; $display("FAIL active_wr ack=%b err=%b exp=1/0", ack_o, err_o); end
        @(negedge clk_i);
        checks++; if (param_o !== snap) begin failures++; $display("FAIL active_wr_ignored got=%h exp=%h", param_o, snap); end
        bus(0, 1, 13'h085, 0);
        checks++; if (rdata_o !== 32'h100 || err_o !== 1'b0) begin failures++; $display("FAIL active_rd got=%h err=%b exp=100/0", rdata_o, err_o); end
    endtask

    task automatic test_back_to_back;
        bus(1, 1, 13'h000, 1);
        checks++; if (rdata_o !== 32'h0 || ack_o !== 1'b1 || bypass_o !== 1'b1) begin failures++; $display("FAIL wr_rd_same rdata=%h ack=%b bypass=%b exp=0/1/1", rdata_o, ack_o, bypass_o); end
        bus(0, 1, 13'h000, 0);
        checks++; if (rdata_o !== 32'h1) begin failures++; $display("FAIL bypass_rd got=%h exp=1", rdata_o); end
        bus(0, 1, 13'h002, 0);
        checks++; if (ack_o !== 1'b1 || rdata_o !== 32'h30) begin failures++; $display("FAIL b2b_a ack=%b rdata=%h exp=1/30", ack_o, rdata_o); end
        bus(0, 1, 13'h003, 0);
        checks++; if (ack_o !== 1'b1 || rdata_o !== 32'h0) begin failures++; $display("FAIL b2b_b ack=%b rdata=%h exp=1/0", ack_o, rdata_o); end
    endtask

    task automatic test_random;
        logic [255:0] mp;
        logic [31:0]  r, d;
        logic [15:0]  s;
        int k, midx, uidx, t;
        for (int i = 0; i < 400; i++) begin
            r = $urandom();
            s = r[0] ? 16'($urandom_range(0, 'h300)) : 16'($urandom_range(0, 'hFFFF));
            d = {r[31:16], s};
            k = $urandom_range(0, 15);
            t = $urandom_range(0, 5);
            midx = (t < 4) ? t : ((t == 4) ? 16 + k : 128 + k);
            t = $urandom_range(0, 2);
            uidx = (t == 0) ? $urandom_range(4, 15) : ((t == 1) ? $urandom_range(32, 127) : $urandom_range(144, 8191));
            case ($urandom_range(0, 9))
                0: bus(1, 0, 13'h000, d);
                1: bus(1, 0, 13'h001, d);
                2: bus(1, 0, 13'h002, {r[31:16], ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(1, 'h200))});
                3: bus(1, 0, 13'h003, {r[31:16], 16'($urandom_range(0, 3))});
                4, 5: bus(1, 0, 13'(16 + k), d);
                6: bus(0, 1, 13'(midx), d);
                7: bus(r[2], !r[2], 13'(uidx), d);
                8: bus(1, 1, 13'(midx), d);
                default: @(negedge clk_i);
            endcase
            for (int j = 0; j < 16; j++) mp[j*16 +: 16] = m_active[j][15:0];
            checks++; if (param_o !== mp) begin failures++; $display("FAIL rnd_param it=%0d got=%h exp=%h", i, param_o, mp); end
            checks++; if (busy_o !== m_busy || done_o !== m_done) begin failures++; $display("FAIL rnd_busy it=%0d got=%b%b exp=%b%b", i, busy_o, done_o, m_busy, m_done); end
            checks++; if (ack_o !== m_ack || err_o !== m_err) begin failures++; $display("FAIL rnd_ack it=%0d got=%b%b exp=%b%b", i, ack_o, err_o, m_ack, m_err); end
            checks++; if (rdata_o !== m_rdata) begin failures++; $display("FAIL rnd_rdata it=%0d got=%h exp=%h", i, rdata_o, m_rdata); end
            checks++; if (bypass_o !== m_bypass) begin failures++; $display("FAIL rnd_bypass it=%0d got=%b exp=%b", i, bypass_o, m_bypass); end
        end
    endtask

    task automatic test_reset_midramp;
        bus(1, 0, 13'h003, 0);
        bus(1, 0, 13'h002, 1);
        bus(1, 0, 13'h015, 32'hFFFF);
        bus(1, 0, 13'h001, 1);
        bus(0, 1, 13'h000, 0);
        repeat (4) @(negedge clk_i);
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL pre_rst_busy got=%b exp=1", busy_o); end
        #2 rstn_i = 1'b0;
        #1;
        checks++; if (param_o !== '0 || busy_o !== 1'b0 || done_o !== 1'b0) begin failures++; $display("FAIL async_rst param=%h busy=%b done=%b exp=0", param_o, busy_o, done_o); end
        checks++; if (ack_o !== 1'b0 || err_o !== 1'b0 || rdata_o !== '0 || bypass_o !== 1'b0) begin failures++; $display("FAIL async_rst_bus ack=%b err=%b rdata=%h bypass=%b exp=0", ack_o, err_o, rdata_o, bypass_o); end
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(negedge clk_i);
        checks++; if (done_o !== 1'b0 || param_o !== '0) begin failures++; $display("FAIL post_rst done=%b param=%h exp=0", done_o, param_o); end
        bus(0, 1, 13'h015, 0);
        checks++; if (rdata_o !== '0) begin failures++; $display("FAIL post_rst_shadow got=%h exp=0", rdata_o); end
        bus(0, 1, 13'h003, 0);
        checks++; if (rdata_o !== 32'd1000) begin failures++; $display("FAIL post_rst_div got=%0d exp=1000", rdata_o); end
    endtask

    initial begin
        test_reset();
        test_shadow();
        test_ramp();
        test_midramp();
        test_clip();
        test_err();
        test_back_to_back();
        test_random();
        test_reset_midramp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
